// File: rtl/button_pkg.sv
// Shared definitions for the button manager register map and the event poller.
package button_pkg;

  localparam logic [7:0] OFF_DAYNIGHT = 8'h00;
  localparam logic [7:0] OFF_MODE     = 8'h04;
  localparam logic [7:0] OFF_TRIP     = 8'h08;
  localparam logic [7:0] OFF_SETTING  = 8'h0C;
  localparam logic [7:0] OFF_NEWDATA  = 8'h10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Button timing constants at the 32 kHz system clock.
  localparam int unsigned CYC_500MS = 32'd16000;
  localparam int unsigned CYC_25MS  = 32'd800;

  typedef enum logic [1:0] {
    EVT_SETTING  = 2'd0,
    EVT_DAYNIGHT = 2'd1,
    EVT_TRIP     = 2'd2,
    EVT_MODE     = 2'd3
  } evt_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_PUSH    = 3'd4,
    ST_RELEASE = 3'd5
  } poll_state_t;

  // Read list position -> register offset; index 1..4 map to event kinds 0..3.
  function automatic logic [7:0] read_offset(input logic [2:0] idx);
    case (idx)
      3'd0:    read_offset = OFF_NEWDATA;
      3'd1:    read_offset = OFF_SETTING;
      3'd2:    read_offset = OFF_DAYNIGHT;
      3'd3:    read_offset = OFF_TRIP;
      3'd4:    read_offset = OFF_MODE;
      default: read_offset = OFF_NEWDATA;
    endcase
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous event queue with full/empty flags; push and pop may coincide.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Head entry is forced to zero when the queue is empty.
  always_comb begin
    rdata = '0;
    if (!empty) begin
      rdata = mem_r[rd_ptr_r];
    end else begin
      rdata = '0;
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/button_event_poller.sv
// AHB-Lite master that polls the button manager each tick and queues at most one event per poll.
module button_event_poller
  import button_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 3200,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        Enable,
  output logic        BusReq,
  input  logic        BusGrant,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic        Evt_Valid,
  input  logic        Evt_Ready,
  output logic [5:0]  Evt_Data,
  output logic        Irq
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [TW-1:0] timer_r;
  logic          tick_pending_r;
  poll_state_t   state_r, state_s;
  logic [2:0]    idx_r, idx_s;
  logic [3:0]    value_r, value_s;
  evt_kind_t     kind_r, kind_s;
  logic          busreq_r;
  logic [31:0]   haddr_r;
  logic          irq_r;
  logic          consume_s;
  logic          push_s;
  logic          full_s;
  logic          empty_s;
  logic          unused_hrdata_s;

  assign unused_hrdata_s = ^HRDATA[31:4];

  // Poll tick timer; a deferred tick stays pending until the queue has room.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      timer_r        <= '0;
      tick_pending_r <= 1'b0;
    end else if (!Enable) begin
      timer_r        <= '0;
      tick_pending_r <= 1'b0;
    end else if (timer_r == TIMER_LAST) begin
      timer_r        <= '0;
      tick_pending_r <= 1'b1;
    end else begin
      timer_r        <= timer_r + TIMER_ONE;
      tick_pending_r <= tick_pending_r && !consume_s;
    end
  end

  // Next-state and bus-phase decode for the poll sequence.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    value_s   = value_r;
    kind_s    = kind_r;
    consume_s = 1'b0;
    push_s    = 1'b0;
    HTRANS    = HTRANS_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (tick_pending_r && !full_s) begin
          state_s   = ST_REQ;
          consume_s = 1'b1;
          idx_s     = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (BusGrant) state_s = ST_ADDR;
        else          state_s = ST_REQ;
      end
      ST_ADDR: begin
        if (BusGrant) begin
          HTRANS  = HTRANS_NONSEQ;
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (!HREADY) begin
          state_s = ST_DATA;
        end else if ((HRDATA[3:0] != 4'd0) && (idx_r != 3'd0)) begin
          // First non-zero store clears them all, so it is the only event this poll.
          value_s = HRDATA[3:0];
          kind_s  = evt_kind_t'(idx_r[1:0] - 2'd1);
          state_s = ST_PUSH;
        end else if ((HRDATA[3:0] == 4'd0) && ((idx_r == 3'd0) || (idx_r == 3'd4))) begin
          state_s = ST_RELEASE;
        end else begin
          idx_s   = idx_r + 3'd1;
          state_s = ST_ADDR;
        end
      end
      ST_PUSH: begin
        push_s  = 1'b1;
        state_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        idx_s   = 3'd0;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered bus/interrupt outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r  <= ST_IDLE;
      idx_r    <= 3'd0;
      value_r  <= 4'd0;
      kind_r   <= EVT_SETTING;
      busreq_r <= 1'b0;
      haddr_r  <= BASE_ADDR + {24'd0, OFF_NEWDATA};
      irq_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      value_r  <= value_s;
      kind_r   <= kind_s;
      busreq_r <= (state_s == ST_REQ) || (state_s == ST_ADDR) || (state_s == ST_DATA);
      haddr_r  <= BASE_ADDR + {24'd0, read_offset(idx_s)};
      irq_r    <= !empty_s;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (6)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push_s),
    .pop   (Evt_Ready),
    .wdata ({kind_r, value_r}),
    .rdata (Evt_Data),
    .full  (full_s),
    .empty (empty_s)
  );

  assign BusReq    = busreq_r;
  assign HADDR     = haddr_r;
  assign HWRITE    = 1'b0;
  assign HSIZE     = 3'b010;
  assign HWDATA    = 32'd0;
  assign Evt_Valid = !empty_s;
  assign Irq       = irq_r;

endmodule

// File: tb/tb_button_event_poller.sv
// Directed bench: button manager slave model plus hand-computed expectations per step.
module tb_button_event_poller;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        Enable;
  logic        BusReq;
  logic        BusGrant;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        Evt_Valid;
  logic        Evt_Ready;
  logic [5:0]  Evt_Data;
  logic        Irq;

  int total = 0;
  int bad   = 0;

  // Slave model state
  logic [3:0]  st_set, st_dn, st_trip, st_mode;
  logic        dphase;
  logic [7:0]  daddr;
  logic [31:0] addr_log[$];
  int          busreq_cnt;

  always #5 HCLK = ~HCLK;

  button_event_poller dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .Enable    (Enable),
    .BusReq    (BusReq),
    .BusGrant  (BusGrant),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .Evt_Valid (Evt_Valid),
    .Evt_Ready (Evt_Ready),
    .Evt_Data  (Evt_Data),
    .Irq       (Irq)
  );

  function automatic logic [3:0] rd_val(input logic [7:0] a, input logic [3:0] s, d, t, m);
    case (a)
      8'h10:   rd_val = ((s | d | t | m) != 4'd0) ? 4'd1 : 4'd0;
      8'h0C:   rd_val = s;
      8'h00:   rd_val = d;
      8'h08:   rd_val = t;
      8'h04:   rd_val = m;
      default: rd_val = 4'd0;
    endcase
  endfunction

  // Garbage while the data phase is stretched so early capture shows up.
  assign HRDATA = (dphase && HREADY) ? {28'd0, rd_val(daddr, st_set, st_dn, st_trip, st_mode)}
                                     : 32'hA5A5_A5A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample bus before the edge, advance the slave model after it.
  task automatic cyc();
    logic [1:0]  ht;
    logic [31:0] ha;
    logic        hr, rs, br;
    #1;
    ht = HTRANS; ha = HADDR; hr = HREADY; rs = HRESET; br = BusReq;
    @(posedge HCLK);
    #1;
    if (br) busreq_cnt++;
    if (rs) begin
      dphase = 1'b0;
    end else begin
      if (dphase && hr) begin
        if (daddr != 8'h10 && rd_val(daddr, st_set, st_dn, st_trip, st_mode) != 4'd0) begin
          st_set = 4'd0; st_dn = 4'd0; st_trip = 4'd0; st_mode = 4'd0;
        end
        dphase = 1'b0;
      end
      if (ht == 2'b10) begin
        dphase = 1'b1;
        daddr  = ha[7:0];
        addr_log.push_back(ha);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_busreq(input int budget, output int n);
    n = 0;
    while (BusReq !== 1'b1 && n < budget) begin cyc(); n++; end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (Evt_Valid !== 1'b1 && n < budget) begin cyc(); n++; end
  endtask

  task automatic pop1();
    Evt_Ready = 1'b1; cyc(); Evt_Ready = 1'b0;
  endtask

  initial begin
    int n;
    logic ok;
    HRESET = 1'b1; Enable = 1'b0; BusGrant = 1'b1; HREADY = 1'b1; Evt_Ready = 1'b0;
    st_set = 4'd0; st_dn = 4'd0; st_trip = 4'd0; st_mode = 4'd0;
    dphase = 1'b0; daddr = 8'h00; busreq_cnt = 0;
    run(3);
    chk("rst_busreq", {31'd0, BusReq}, 32'd0);
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'h4000_0010);
    chk("rst_valid", {31'd0, Evt_Valid}, 32'd0);
    chk("rst_data", {26'd0, Evt_Data}, 32'd0);
    chk("rst_irq", {31'd0, Irq}, 32'd0);
    chk("const_bus", {HWDATA[31:4], HWRITE, HSIZE}, {28'd0, 1'b0, 3'b010});

    // NewData = 0: one read, 3 cycles of BusReq, period 3200
    HRESET = 1'b0; Enable = 1'b1;
    wait_busreq(4000, n);
    chk("first_tick_cycles", n, 32'd3201);
    addr_log.delete(); busreq_cnt = 0;
    run(10);
    chk("idle_poll_reads", addr_log.size(), 32'd1);
    if (addr_log.size() > 0) chk("idle_poll_addr", addr_log[0], 32'h4000_0010);
    chk("idle_poll_busreq", busreq_cnt, 32'd3);
    chk("idle_poll_noevt", {31'd0, Evt_Valid}, 32'd0);
    wait_busreq(4000, n);
    chk("tick_period", n + 10, 32'd3200);
    run(10);

    // Mode = 3 only: full read list, worst-case latency
    st_mode = 4'd3; addr_log.delete();
    wait_busreq(4000, n);
    wait_valid(50, n);
    chk("mode_latency", n, 32'd12);
    chk("mode_reads", addr_log.size(), 32'd5);
    if (addr_log.size() == 5) begin
      chk("mode_rd0", addr_log[0], 32'h4000_0010);
      chk("mode_rd1", addr_log[1], 32'h4000_000C);
      chk("mode_rd2", addr_log[2], 32'h4000_0000);
      chk("mode_rd3", addr_log[3], 32'h4000_0008);
      chk("mode_rd4", addr_log[4], 32'h4000_0004);
    end
    chk("mode_data", {26'd0, Evt_Data}, {26'd0, 6'b11_0011});
    chk("irq_lag0", {31'd0, Irq}, 32'd0);
    cyc();
    chk("irq_lag1", {31'd0, Irq}, 32'd1);
    pop1();
    chk("pop_empty", {31'd0, Evt_Valid}, 32'd0);

    // Setting = 1 and Trip = 2: only Setting reported, Trip never read
    st_set = 4'd1; st_trip = 4'd2; addr_log.delete();
    wait_busreq(4000, n);
    wait_valid(50, n);
    run(3);
    chk("set_data", {26'd0, Evt_Data}, {26'd0, 6'b00_0001});
    chk("set_reads", addr_log.size(), 32'd2);
    pop1();

    // Consumer stalls: 4 events fill the queue, 5th poll deferred
    for (int i = 0; i < 4; i++) begin
      st_mode = 4'(i + 1);
      wait_busreq(4000, n);
      run(16);
    end
    chk("full_head", {26'd0, Evt_Data}, {26'd0, 6'b11_0001});
    st_mode = 4'd5; addr_log.delete(); busreq_cnt = 0;
    run(3300);
    chk("defer_reads", addr_log.size(), 32'd0);
    chk("defer_busreq", busreq_cnt, 32'd0);
    chk("defer_head", {26'd0, Evt_Data}, {26'd0, 6'b11_0001});
    pop1();
    wait_busreq(5, n);
    chk("defer_resume", n, 32'd1);
    run(16);
    chk("resume_reads", addr_log.size(), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", {26'd0, Evt_Data}, {26'd0, 2'b11, 4'(i + 2)});
      pop1();
    end
    chk("drain_empty", {31'd0, Evt_Valid}, 32'd0);

    // Grant withheld in ADDR, then HREADY stretches DATA
    st_set = 4'd9; addr_log.delete();
    wait_busreq(4000, n);
    cyc(); cyc();
    BusGrant = 1'b0;
    cyc();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (HTRANS !== 2'b00 || BusReq !== 1'b1) ok = 1'b0;
      cyc();
    end
    chk("nogrant_idle", {31'd0, ok}, 32'd1);
    BusGrant = 1'b1; #1;
    chk("grant_nonseq", {30'd0, HTRANS}, 32'd2);
    chk("grant_haddr", HADDR, 32'h4000_000C);
    HREADY = 1'b0;
    cyc();
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (HTRANS !== 2'b00 || BusReq !== 1'b1) ok = 1'b0;
      cyc();
    end
    chk("stretch_hold", {31'd0, ok}, 32'd1);
    HREADY = 1'b1;
    wait_valid(10, n);
    chk("stretch_data", {26'd0, Evt_Data}, {26'd0, 6'b00_1001});
    chk("stretch_reads", addr_log.size(), 32'd2);
    run(3);

    // Reset mid-DATA aborts everything and restarts the timer
    st_mode = 4'd2;
    wait_busreq(4000, n);
    cyc(); cyc();
    HRESET = 1'b1; cyc(); HRESET = 1'b0;
    chk("abort_busreq", {31'd0, BusReq}, 32'd0);
    chk("abort_htrans", {30'd0, HTRANS}, 32'd0);
    chk("abort_valid", {31'd0, Evt_Valid}, 32'd0);
    chk("abort_haddr", HADDR, 32'h4000_0010);
    wait_busreq(4000, n);
    chk("abort_restart", n, 32'd3201);
    wait_valid(50, n);
    chk("abort_repoll", {26'd0, Evt_Data}, {26'd0, 6'b11_0010});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
